// File: rtl/mux_16to1_sync_pkg.sv
// Shared constants for the registered 16:1 select slice.
package mux_16to1_sync_pkg;

  localparam int unsigned SEL_W   = 4;
  localparam int unsigned NUM_IN  = 16;
  localparam int unsigned GRP_SEL = 2;
  localparam int unsigned NUM_GRP = NUM_IN / (1 << GRP_SEL);

endpackage

// File: rtl/mux_16to1_sync_mux_4to1.sv
// Purely combinational 4:1 single-bit mux; leaf of the 16:1 select tree.
module mux_4to1 (
  input  logic [1:0] s,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  output logic       z
);

  // Nested ternaries let an X on the selected input (or on s) reach z.
  assign z = s[1] ? (s[0] ? i3 : i2) : (s[0] ? i1 : i0);

endmodule

// File: rtl/mux_16to1_sync.sv
// Registered 16:1 single-bit mux: two levels of 4:1 muxes feeding one flop.
module mux_16to1_sync
  import mux_16to1_sync_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] s,
  input  logic             i0,
  input  logic             i1,
  input  logic             i2,
  input  logic             i3,
  input  logic             i4,
  input  logic             i5,
  input  logic             i6,
  input  logic             i7,
  input  logic             i8,
  input  logic             i9,
  input  logic             i10,
  input  logic             i11,
  input  logic             i12,
  input  logic             i13,
  input  logic             i14,
  input  logic             i15,
  output logic             z
);

  logic [NUM_GRP-1:0] grp;
  logic               sel;

  mux_4to1 u_grp0 (.s(s[1:0]), .i0(i0),  .i1(i1),  .i2(i2),  .i3(i3),  .z(grp[0]));
  mux_4to1 u_grp1 (.s(s[1:0]), .i0(i4),  .i1(i5),  .i2(i6),  .i3(i7),  .z(grp[1]));
  mux_4to1 u_grp2 (.s(s[1:0]), .i0(i8),  .i1(i9),  .i2(i10), .i3(i11), .z(grp[2]));
  mux_4to1 u_grp3 (.s(s[1:0]), .i0(i12), .i1(i13), .i2(i14), .i3(i15), .z(grp[3]));

  mux_4to1 u_top (
    .s (s[3:2]),
    .i0(grp[0]),
    .i1(grp[1]),
    .i2(grp[2]),
    .i3(grp[3]),
    .z (sel)
  );

  always_ff @(posedge clk) begin
    if (reset) z <= 1'b0;
    else       z <= sel;
  end

endmodule

// File: tb/tb_mux_16to1_sync.sv
// Scoreboard bench for mux_16to1_sync: driver queues expected z, monitor checks it.
module tb_mux_16to1_sync;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  s;
  logic [15:0] din;
  logic        z;

  logic        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mux_16to1_sync dut (
    .clk  (clk),
    .reset(reset),
    .s    (s),
    .i0 (din[0]),  .i1 (din[1]),  .i2 (din[2]),  .i3 (din[3]),
    .i4 (din[4]),  .i5 (din[5]),  .i6 (din[6]),  .i7 (din[7]),
    .i8 (din[8]),  .i9 (din[9]),  .i10(din[10]), .i11(din[11]),
    .i12(din[12]), .i13(din[13]), .i14(din[14]), .i15(din[15]),
    .z    (z)
  );

  // Reference: reset wins, otherwise the input whose index equals s.
  function automatic logic model(input logic r, input logic [3:0] sel, input logic [15:0] d);
    int unsigned idx;
    idx = sel;
    return r ? 1'b0 : d[idx];
  endfunction

  task automatic drive(input logic r, input logic [3:0] sel, input logic [15:0] d);
    @(negedge clk);
    reset = r;
    s     = sel;
    din   = d;
    exp_q.push_back(model(r, sel, d));
  endtask

  // Monitor: z is valid one step after every rising edge that had stimulus queued.
  initial begin
    logic e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (z !== e) begin
          n_bad++;
          $display("FAIL scoreboard t=%0t s=%0d din=%h: z=%b required %b", $time, s, din, z, e);
        end
      end
    end
  end

  initial begin
    logic [15:0] d;
    int          wait_cyc;
    reset = 1'b1;
    s     = '0;
    din   = '0;

    // Reset held with all ones selected at 15, then release.
    drive(1'b1, 4'hF, 16'hFFFF);
    drive(1'b1, 4'hF, 16'hFFFF);
    drive(1'b0, 4'hF, 16'hFFFF);

    // i2, i4, i5 high.
    d = 16'h0034;
    drive(1'b0, 4'b0010, d);
    drive(1'b0, 4'b0011, d);
    drive(1'b0, 4'b0111, d);
    d[7] = 1'b0;
    drive(1'b0, 4'b0111, d);
    drive(1'b0, 4'b0101, d);
    d[4] = ~d[4];
    drive(1'b0, 4'b0101, d);
    d[6] = ~d[6];
    drive(1'b0, 4'b0101, d);
    d[4] = ~d[4];
    d[6] = ~d[6];
    drive(1'b0, 4'b0101, d);

    // Top and middle indices.
    d[15] = 1'b1;
    drive(1'b0, 4'b1111, d);
    d[10] = 1'b1;
    drive(1'b0, 4'b1010, d);
    d[10] = 1'b0;
    drive(1'b0, 4'b1010, d);

    // Walking one across every input and every select.
    for (int n = 0; n < 16; n++)
      for (int k = 0; k < 16; k++)
        drive(1'b0, 4'(k), 16'h0001 << n);

    // Latency: z must hold its old value when s changes just after an edge.
    drive(1'b0, 4'd3, 16'h0008);
    @(posedge clk);
    #2;
    s = 4'd0;
    #1;
    n_cmp++;
    if (z !== 1'b1) begin
      n_bad++;
      $display("FAIL latency_hold: z=%b required 1", z);
    end
    drive(1'b0, 4'd0, 16'h0008);

    // Mid-stream reset followed by resume.
    drive(1'b0, 4'd9, 16'h0200);
    drive(1'b1, 4'd9, 16'h0200);
    drive(1'b0, 4'd9, 16'h0200);

    // Random traffic with occasional reset pulses.
    for (int c = 0; c < 400; c++)
      drive(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)), 16'($urandom));

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      #2;
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
